fir_mac_secuencial: RTL and testbench
=====================================

Name: fir_mac_secuencial

Overview:
- Sequential 10-tap FIR filter that reads the coefficient memory: drives the 4-bit coefficient index (estados) and consumes the returned signed coefficient (Constantes).
- One multiply-accumulate per clock. Produces one filtered sample per accepted input sample.
- Sits between the sampled error/position path and the servo control law.

Parameters:
- cant_bits, 13, width of input samples, coefficients and output; signed Q4.8 (1 sign, 4 integer, 8 fraction bits).
- frac_bits, 8, number of fraction bits removed after accumulation.
- n_taps, 10, number of taps/coefficients used (indices 0..n_taps-1); legal range 1..16.

Ports:
- clk, in, 1, system clock; all state updates on the rising edge.
- reset, in, 1, asynchronous, active-high reset.
- start, in, 1, new-sample strobe; sampled only in IDLE.
- din, in, cant_bits, signed input sample, captured when start is accepted.
- Constantes, in, cant_bits, signed coefficient returned combinationally by the coefficient memory for the current estados.
- estados, out, 4, coefficient index driven to the coefficient memory.
- y, out, cant_bits, signed filtered output, registered, held between results.
- listo, out, 1, one-cycle pulse when y is updated.
- busy, out, 1, high while a computation is in progress (state != IDLE).

Behaviour:
- Reset (async, takes effect immediately, including mid-computation):
  - state = IDLE; estados = 0; y = 0; listo = 0; busy = 0.
  - Accumulator cleared; all delay-line registers x[0..n_taps-1] cleared.
  - An interrupted computation produces no output.
- Delay line: x[0] is the newest sample. On accept: x[0] <= din and x[k] <= x[k-1]; the oldest sample is dropped.
- States:
  - IDLE: listo is deasserted after one cycle. If start=1 at edge E: shift the delay line, acc <= 0, estados <= 0, go to MAC.
  - MAC: each edge, acc <= acc + x[estados]*Constantes and estados <= estados+1. The edge that processes estados = n_taps-1 goes to OUT.
  - OUT: y <= sat(acc >>> frac_bits); listo <= 1; estados <= 0; go to IDLE.
- Latency:
  - Start sampled at edge E; MAC edges are E+1..E+n_taps.
  - y and listo update at edge E+n_taps+1 (E+11 by default); listo is high for exactly one cycle.
  - busy is high from E to E+n_taps+1.
  - A start coincident with the listo-high cycle is accepted, giving a back-to-back throughput of one sample per n_taps+2 clocks.
- start while busy: ignored and dropped; no queuing, delay line untouched.
- Arithmetic:
  - Product is 2*cant_bits signed bits.
  - Accumulator is 2*cant_bits+4 signed bits; it never overflows for 16 taps.
  - Shift is arithmetic, truncating toward minus infinity (no rounding).
  - Saturation clamps to [-2^(cant_bits-1), 2^(cant_bits-1)-1], i.e. [-4096, 4095].
- Coefficient memory is combinational: Constantes is valid in the same cycle estados is driven. estados never exceeds n_taps-1.

Test Plan:
- Impulse: after reset, din=256 (1.0) once, then 10 samples of 0.
  - Successive y = 196, 159, 122, 49, 12, -25, -62, -98, -135, -172, then 0.
  - Each listo arrives 11 clocks after its start.
- DC step: 10 consecutive samples of din=256 → 10th y = 46. Further samples of 256 keep y at 46.
- Saturation:
  - After reset, 5 samples of din=4095 → 5th y = 4095 (unsaturated value 8605).
  - After reset, 5 samples of din=-4096 → 5th y = -4096.
- Negative truncation: after reset, din=-1 once → y = -1 (floor of -196/256). Next sample of 0 → y = -1 (floor of -159/256).
- Dropped start: pulse start with din=256, then pulse start again with din=1000 at E+4.
  - Only one listo is produced, with y=196; busy is high at E+4.
  - The next accepted sample of 0 yields 159, proving 1000 never entered the delay line.
- Reset mid-MAC: assert reset at E+5.
  - y=0, listo=0, busy=0, estados=0 immediately.
  - No listo follows; the next impulse of 256 yields 196.

Source files
------------

// File: rtl/fir_mac_secuencial.sv
// Sequential FIR filter: one multiply-accumulate per clock against an external
// combinational coefficient memory addressed by estados. One output per
// accepted sample, saturated back to the input Q4.8 format.
module fir_mac_secuencial #(
  parameter int cant_bits = 13,
  parameter int frac_bits = 8,
  parameter int n_taps    = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic signed [cant_bits-1:0] din,
  input  logic signed [cant_bits-1:0] Constantes,
  output logic        [3:0]           estados,
  output logic signed [cant_bits-1:0] y,
  output logic                        listo,
  output logic                        busy
);

  localparam int PW = 2*cant_bits;
  // 4 guard bits cover the worst-case sum over 16 taps
  localparam int AW = 2*cant_bits + 4;
  localparam logic signed [AW-1:0] YMAX = AW'(2**(cant_bits-1) - 1);
  localparam logic signed [AW-1:0] YMIN = AW'(-(2**(cant_bits-1)));

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                             state, state_nxt;
  logic [n_taps-1:0][cant_bits-1:0]   x;        // x[0] is the newest sample
  logic signed [AW-1:0]               acc;
  logic signed [cant_bits-1:0]        xsel;
  logic signed [PW-1:0]               prod;
  logic signed [AW-1:0]               prod_ext;
  logic signed [AW-1:0]               shifted;
  logic signed [cant_bits-1:0]        ysat;
  logic                               last;

  assign last     = (estados == 4'(n_taps-1));
  assign busy     = (state != IDLE);
  assign prod     = xsel * Constantes;
  assign prod_ext = {{(AW-PW){prod[PW-1]}}, prod};
  assign shifted  = acc >>> frac_bits;

  // Select the delay-line tap addressed by estados; explicit mux keeps the
  // index in range when n_taps is not a power of two.
  always_comb begin
    xsel = '0;
    for (int k = 0; k < n_taps; k++)
      if (estados == 4'(k)) xsel = x[k];
  end

  // Clamp the rescaled accumulator into the output range
  always_comb begin
    ysat = shifted[cant_bits-1:0];
    if (shifted > YMAX)      ysat = YMAX[cant_bits-1:0];
    else if (shifted < YMIN) ysat = YMIN[cant_bits-1:0];
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: start only matters in IDLE, so starts while busy are dropped
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MAC;
      MAC:     if (last)  state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: delay line, accumulator, coefficient index, output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x       <= '0;
      acc     <= '0;
      estados <= '0;
      y       <= '0;
      listo   <= 1'b0;
    end else begin
      listo <= 1'b0;
      case (state)
        IDLE: if (start) begin
          x[0] <= din;
          for (int k = 1; k < n_taps; k++) x[k] <= x[k-1];
          acc     <= '0;
          estados <= '0;
        end
        MAC: begin
          acc     <= acc + prod_ext;
          // wrap to 0 on the last tap so estados never leaves 0..n_taps-1
          estados <= last ? 4'd0 : estados + 4'd1;
        end
        OUT: begin
          y       <= ysat;
          listo   <= 1'b1;
          estados <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_secuencial.sv
// Self-checking bench for fir_mac_secuencial: directed scenarios from the
// filter's documented responses plus randomized samples against a sum-of-
// products reference model.
module tb_fir_mac_secuencial;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic signed [12:0] din;
  logic signed [12:0] Constantes;
  logic [3:0]         estados;
  logic signed [12:0] y;
  logic               listo;
  logic               busy;

  int checks   = 0;
  int failures = 0;

  int coef [10] = '{196, 159, 122, 49, 12, -25, -62, -98, -135, -172};
  int hist [10];

  fir_mac_secuencial dut (
    .clk(clk), .reset(reset), .start(start), .din(din),
    .Constantes(Constantes), .estados(estados), .y(y),
    .listo(listo), .busy(busy)
  );

  always #5 clk = ~clk;

  // Coefficient memory: combinational lookup
  always_comb begin
    Constantes = 13'sd0;
    if (estados < 4'd10) Constantes = 13'(coef[estados]);
  end

  // ---------------- reference model ----------------
  function automatic void model_reset();
    for (int k = 0; k < 10; k++) hist[k] = 0;
  endfunction

  function automatic void model_push(int d);
    for (int k = 9; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = d;
  endfunction

  function automatic int model_y();
    longint s = 0;
    longint q;
    for (int k = 0; k < 10; k++) s += longint'(hist[k]) * longint'(coef[k]);
    q = s / 256;
    if (s < 0 && (s % 256) != 0) q = q - 1;   // floor
    if (q > 4095)  q = 4095;
    if (q < -4096) q = -4096;
    return int'(q);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic reset_dut();
    reset = 1'b1; start = 1'b0; din = '0;
    #3 reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
  endtask

  // Drive one sample (after gap idle cycles), wait for its result and check
  // latency and value against the model. Leaves time at #1 after the listo edge.
  task automatic do_sample(input int d, input int gap, input string tag, output int yo);
    int cnt;
    int exp;
    repeat (gap) begin @(posedge clk); #1; end
    start = 1'b1; din = 13'(d);
    @(posedge clk); #1;
    start = 1'b0;
    model_push(d);
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL %s busy_after_accept got=%b exp=1", tag, busy);
    end
    cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (listo === 1'b1) begin cnt = i; break; end
    end
    checks++;
    if (cnt != 11) begin
      failures++; $display("FAIL %s latency got=%0d exp=11", tag, cnt);
    end
    exp = model_y();
    checks++;
    if (y !== 13'(exp)) begin
      failures++; $display("FAIL %s y got=%0d exp=%0d", tag, $signed(y), exp);
    end
    yo = int'($signed(y));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; din = '0;
    @(posedge clk); #1;
    checks++;
    if (y !== 13'sd0 || listo !== 1'b0 || busy !== 1'b0 || estados !== 4'd0) begin
      failures++;
      $display("FAIL reset_state got y=%0d listo=%b busy=%b estados=%0d exp 0/0/0/0",
               $signed(y), listo, busy, estados);
    end
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_impulse();
    int tbl [11] = '{196, 159, 122, 49, 12, -25, -62, -98, -135, -172, 0};
    int yo;
    reset_dut();
    for (int i = 0; i < 11; i++) begin
      do_sample((i == 0) ? 256 : 0, 1, "impulse", yo);
      checks++;
      if (yo != tbl[i]) begin
        failures++; $display("FAIL impulse_tbl[%0d] got=%0d exp=%0d", i, yo, tbl[i]);
      end
    end
  endtask

  task automatic test_dc_step();
    int yo;
    reset_dut();
    for (int i = 0; i < 12; i++) begin
      do_sample(256, 0, "dc_step", yo);
      if (i >= 9) begin
        checks++;
        if (yo != 46) begin
          failures++; $display("FAIL dc_step_y[%0d] got=%0d exp=46", i, yo);
        end
      end
    end
    @(posedge clk); #1;
    checks++;
    if (listo !== 1'b0) begin
      failures++; $display("FAIL listo_one_cycle got=%b exp=0", listo);
    end
  endtask

  task automatic test_saturation();
    int yo;
    reset_dut();
    for (int i = 0; i < 5; i++) do_sample(4095, 0, "sat_pos", yo);
    checks++;
    if (yo != 4095) begin
      failures++; $display("FAIL sat_pos got=%0d exp=4095", yo);
    end
    reset_dut();
    for (int i = 0; i < 5; i++) do_sample(-4096, 0, "sat_neg", yo);
    checks++;
    if (yo != -4096) begin
      failures++; $display("FAIL sat_neg got=%0d exp=-4096", yo);
    end
  endtask

  task automatic test_neg_trunc();
    int yo;
    reset_dut();
    do_sample(-1, 0, "neg_trunc", yo);
    checks++;
    if (yo != -1) begin
      failures++; $display("FAIL neg_trunc_1 got=%0d exp=-1", yo);
    end
    do_sample(0, 0, "neg_trunc", yo);
    checks++;
    if (yo != -1) begin
      failures++; $display("FAIL neg_trunc_2 got=%0d exp=-1", yo);
    end
  endtask

  task automatic test_dropped_start();
    int pulses = 0;
    int ylist  = 0;
    int yo;
    reset_dut();
    start = 1'b1; din = 13'sd256;
    @(posedge clk); #1;                 // edge E
    start = 1'b0;
    model_push(256);
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b1; din = 13'sd1000;
    @(posedge clk); #1;                 // edge E+4
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL dropped_busy got=%b exp=1", busy);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (listo === 1'b1) begin pulses++; ylist = int'($signed(y)); end
    end
    checks++;
    if (pulses != 1) begin
      failures++; $display("FAIL dropped_pulses got=%0d exp=1", pulses);
    end
    checks++;
    if (ylist != 196) begin
      failures++; $display("FAIL dropped_y got=%0d exp=196", ylist);
    end
    do_sample(0, 0, "dropped_next", yo);
    checks++;
    if (yo != 159) begin
      failures++; $display("FAIL dropped_next got=%0d exp=159", yo);
    end
  endtask

  task automatic test_reset_mid_mac();
    int pulses = 0;
    int yo;
    start = 1'b1; din = 13'sd256;
    @(posedge clk); #1;                 // edge E
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    @(posedge clk); #2;                 // just after E+5
    reset = 1'b1;
    #1;
    checks++;
    if (y !== 13'sd0 || listo !== 1'b0 || busy !== 1'b0 || estados !== 4'd0) begin
      failures++;
      $display("FAIL mid_reset got y=%0d listo=%b busy=%b estados=%0d exp 0/0/0/0",
               $signed(y), listo, busy, estados);
    end
    #1 reset = 1'b0;
    model_reset();
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (listo === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++; $display("FAIL mid_reset_listo got=%0d exp=0", pulses);
    end
    do_sample(256, 0, "mid_reset_next", yo);
    checks++;
    if (yo != 196) begin
      failures++; $display("FAIL mid_reset_next got=%0d exp=196", yo);
    end
  endtask

  task automatic test_back_to_back();
    int yo;
    time t_prev;
    reset_dut();
    do_sample(300, 0, "b2b", yo);
    t_prev = $time;
    for (int i = 0; i < 4; i++) begin
      do_sample(int'($urandom_range(0, 8191)) - 4096, 0, "b2b", yo);
      checks++;
      if ($time - t_prev != 120) begin
        failures++; $display("FAIL b2b_period got=%0t exp=120", $time - t_prev);
      end
      t_prev = $time;
    end
  endtask

  task automatic test_random();
    int yo;
    reset_dut();
    for (int i = 0; i < 40; i++)
      do_sample(int'($urandom_range(0, 8191)) - 4096, int'($urandom_range(0, 2)), "random", yo);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; din = '0;
    model_reset();
    #2;
    test_reset();
    test_impulse();
    test_dc_step();
    test_saturation();
    test_neg_trunc();
    test_dropped_start();
    test_reset_mid_mac();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
